// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared types and defaults for the SRAM memory controller
package sram_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, DONE = 2'd3} state_e;
  typedef enum logic {OP_RD = 1'b0, OP_WR = 1'b1} op_e;

  localparam int DEFAULT_WAIT_CYCLES = 1;
  localparam int DEFAULT_BASE_ADDR   = 1024;
  localparam int DEFAULT_SRAM_AW     = 18;
endpackage

// File: rtl/sram_phase_timer.sv
// rtl/sram_phase_timer.sv - loadable down-counter timing one halfword SRAM phase
module sram_phase_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] load_val,
  output logic       last
);
  logic [3:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (start) begin
      count_d = load_val;
    end else if (count_q != 4'd0) begin
      count_d = count_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= 4'd0;
    else        count_q <= count_d;
  end

  assign last = (count_q == 4'd0);
endmodule

// File: rtl/sram_mem_controller.sv
// rtl/sram_mem_controller.sv - 32-bit load/store onto a 16-bit async SRAM as two halfword phases
// Optional access counters: SRAM_CTRL_ACCESS_COUNT_EN
module sram_mem_controller
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
  parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int SRAM_AW     = DEFAULT_SRAM_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_en,
  input  logic               wr_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_we_n
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
  ,
  output logic [15:0]        rd_count,
  output logic [15:0]        wr_count
`endif
);
  localparam int WW = SRAM_AW - 1;

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [WW-1:0]      word_q, word_d;
  logic [15:0]        wdata_hi_q, wdata_hi_d;
  logic [31:0]        read_data_q, read_data_d;
  logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
  logic [15:0]        dq_out_q, dq_out_d;
  logic               oe_q, oe_d;
  logic               we_n_q, we_n_d;
  logic               req, timer_start, phase_last;
  logic [31:0]        offset;
  logic               unused_offset_bits;

  assign req    = rd_en | wr_en;
  assign offset = address - 32'(BASE_ADDR);
  // Out-of-range addresses simply wrap: the discarded upper bits are ignored.
  assign unused_offset_bits = ^{offset[31:SRAM_AW+1], offset[1:0]};

  sram_phase_timer u_timer (
    .clk      (clk),
    .rst_n    (rst),
    .start    (timer_start),
    .load_val (4'(WAIT_CYCLES)),
    .last     (phase_last)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    word_d      = word_q;
    wdata_hi_d  = wdata_hi_q;
    read_data_d = read_data_q;
    sram_addr_d = sram_addr_q;
    dq_out_d    = dq_out_q;
    oe_d        = oe_q;
    we_n_d      = we_n_q;
    timer_start = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        op_d        = wr_en ? OP_WR : OP_RD;
        word_d      = offset[SRAM_AW:2];
        wdata_hi_d  = write_data[31:16];
        sram_addr_d = {offset[SRAM_AW:2], 1'b0};
        if (wr_en) dq_out_d = write_data[15:0];
        oe_d        = wr_en;
        we_n_d      = ~wr_en;
        timer_start = 1'b1;
        state_d     = LOW;
      end
      LOW: if (phase_last) begin
        if (op_q == OP_RD) read_data_d[15:0] = sram_dq_in;
        if (op_q == OP_WR) dq_out_d = wdata_hi_q;
        sram_addr_d = {word_q, 1'b1};
        timer_start = 1'b1;
        state_d     = HIGH;
      end
      HIGH: if (phase_last) begin
        if (op_q == OP_RD) read_data_d[31:16] = sram_dq_in;
        oe_d    = 1'b0;
        we_n_d  = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      op_q        <= OP_RD;
      word_q      <= '0;
      wdata_hi_q  <= 16'h0;
      read_data_q <= 32'h0;
      sram_addr_q <= '0;
      dq_out_q    <= 16'h0;
      oe_q        <= 1'b0;
      we_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      word_q      <= word_d;
      wdata_hi_q  <= wdata_hi_d;
      read_data_q <= read_data_d;
      sram_addr_q <= sram_addr_d;
      dq_out_q    <= dq_out_d;
      oe_q        <= oe_d;
      we_n_q      <= we_n_d;
    end
  end

  assign ready       = (state_q == DONE) | ((state_q == IDLE) & ~req);
  assign read_data   = read_data_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = dq_out_q;
  assign sram_dq_oe  = oe_q;
  assign sram_we_n   = we_n_q;

`ifdef SRAM_CTRL_ACCESS_COUNT_EN
  logic [15:0] rd_count_q, rd_count_d, wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == DONE) begin
      if (op_q == OP_WR) begin
        if (wr_count_q != 16'hFFFF) wr_count_d = wr_count_q + 16'd1;
      end else begin
        if (rd_count_q != 16'hFFFF) rd_count_d = rd_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_count_q <= 16'h0;
      wr_count_q <= 16'h0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_sram_mem_controller.sv
// tb/tb_sram_mem_controller.sv - scoreboard bench for sram_mem_controller with a behavioural SRAM
module tb_sram_mem_controller;
  localparam int AW = 18;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          rd_en = 1'b0, wr_en = 1'b0;
  logic [31:0]   address = 32'h0, write_data = 32'h0;
  logic [31:0]   read_data;
  logic          ready;
  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n;

  logic          w0_wr = 1'b0, w3_wr = 1'b0;
  logic [31:0]   ws_addr = 32'h0, ws_data = 32'h0;
  logic [15:0]   ws_dq_in = 16'h0;
  logic [31:0]   w0_rd, w3_rd;
  logic          w0_ready, w3_ready, w0_oe, w3_oe, w0_we_n, w3_we_n;
  logic [AW-1:0] w0_addr, w3_addr;
  logic [15:0]   w0_dq, w3_dq;
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
  logic [15:0]   rd_count, wr_count, w0_rdc, w0_wrc, w3_rdc, w3_wrc;
`endif

  sram_mem_controller #(.WAIT_CYCLES(1)) u_dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
    .write_data(write_data), .read_data(read_data), .ready(ready),
    .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
    .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  sram_mem_controller #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .rd_en(1'b0), .wr_en(w0_wr), .address(ws_addr),
    .write_data(ws_data), .read_data(w0_rd), .ready(w0_ready),
    .sram_addr(w0_addr), .sram_dq_out(w0_dq), .sram_dq_oe(w0_oe),
    .sram_dq_in(ws_dq_in), .sram_we_n(w0_we_n)
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    , .rd_count(w0_rdc), .wr_count(w0_wrc)
`endif
  );

  sram_mem_controller #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .rd_en(1'b0), .wr_en(w3_wr), .address(ws_addr),
    .write_data(ws_data), .read_data(w3_rd), .ready(w3_ready),
    .sram_addr(w3_addr), .sram_dq_out(w3_dq), .sram_dq_oe(w3_oe),
    .sram_dq_in(ws_dq_in), .sram_we_n(w3_we_n)
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    , .rd_count(w3_rdc), .wr_count(w3_wrc)
`endif
  );

  logic [15:0] mem [0:(1<<AW)-1];
  assign sram_dq_in = mem[sram_addr];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr] = sram_dq_out;
  end

  typedef struct {
    bit          rdy;
    bit          chk;
    logic [AW-1:0] addr;
    bit          we_n;
    bit          oe;
    bit          chk_dq;
    logic [15:0] dq;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          lat_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] last_rd = 32'h0;
  int          exp_rd_cnt = 0, exp_wr_cnt = 0;

  task automatic run_access(input bit do_rd, input bit do_wr, input logic [31:0] a,
                            input logic [31:0] d, input bit keep);
    logic [31:0]   off;
    logic [AW-2:0] w;
    exp_t          e;
    logic [31:0]   exp_rd;
    int            cyc;
    off = a - 32'd1024;
    w   = off[AW:2];
    e = '{rdy: 1'b0, chk: 1'b0, addr: '0, we_n: 1'b1, oe: 1'b0, chk_dq: 1'b0, dq: 16'h0};
    exp_q.push_back(e);
    for (int ph = 0; ph < 2; ph++) begin
      for (int k = 0; k < 2; k++) begin
        e.chk    = 1'b1;
        e.addr   = {w, ph[0]};
        e.we_n   = !do_wr;
        e.oe     = do_wr;
        e.chk_dq = do_wr;
        e.dq     = (ph == 0) ? d[15:0] : d[31:16];
        exp_q.push_back(e);
      end
    end
    e.rdy = 1'b1; e.we_n = 1'b1; e.oe = 1'b0; e.chk_dq = 1'b0; e.addr = {w, 1'b1};
    exp_q.push_back(e);
    if (do_wr) exp_wr_cnt++;
    else begin
      last_rd = {mem[{w, 1'b1}], mem[{w, 1'b0}]};
      exp_rd_cnt++;
    end
    rd_q.push_back(last_rd);

    @(posedge clk); #1;
    rd_en = do_rd; wr_en = do_wr; address = a; write_data = d;
    cyc = 0;
    while (exp_q.size() > 0) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      #1;
      e = exp_q.pop_front();
      checks++;
      if (ready !== e.rdy) begin
        $display("FAIL ready a=%h cyc=%0d got=%b exp=%b", a, cyc, ready, e.rdy);
        errors++;
      end
      if (e.chk) begin
        checks++;
        if ({sram_addr, sram_we_n, sram_dq_oe} !== {e.addr, e.we_n, e.oe}) begin
          $display("FAIL sram_ctl a=%h cyc=%0d got addr=%h we_n=%b oe=%b exp addr=%h we_n=%b oe=%b",
                   a, cyc, sram_addr, sram_we_n, sram_dq_oe, e.addr, e.we_n, e.oe);
          errors++;
        end
        if (e.chk_dq) begin
          checks++;
          if (sram_dq_out !== e.dq) begin
            $display("FAIL dq_out a=%h cyc=%0d got=%h exp=%h", a, cyc, sram_dq_out, e.dq);
            errors++;
          end
        end
      end
      cyc++;
    end
    exp_rd = rd_q.pop_front();
    checks++;
    if (read_data !== exp_rd) begin
      $display("FAIL read_data a=%h got=%h exp=%h", a, read_data, exp_rd);
      errors++;
    end
    if (!keep) begin rd_en = 1'b0; wr_en = 1'b0; end
  endtask

  task automatic test_reset;
    rst = 1'b1; #2 rst = 1'b0; #1;
    checks++;
    if ({ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n} !==
        {1'b1, 32'h0, 18'h0, 16'h0, 1'b0, 1'b1}) begin
      $display("FAIL reset_main got rdy=%b rd=%h addr=%h dq=%h oe=%b we_n=%b",
               ready, read_data, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n);
      errors++;
    end
    checks++;
    if ({w0_rd, w3_rd, w0_addr, w3_addr, w0_dq, w3_dq, w0_oe, w3_oe, w0_we_n, w3_we_n, w0_ready, w3_ready} !==
        {64'h0, 36'h0, 32'h0, 2'b00, 2'b11, 2'b11}) begin
      $display("FAIL reset_ws got w0_we_n=%b w3_we_n=%b w0_addr=%h w3_addr=%h", w0_we_n, w3_we_n, w0_addr, w3_addr);
      errors++;
    end
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    checks++;
    if ({rd_count, wr_count} !== 32'h0) begin
      $display("FAIL reset_counts got rd=%0d wr=%0d exp 0", rd_count, wr_count);
      errors++;
    end
`endif
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_write;
    run_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, 1'b0);
    checks++;
    if ({mem[1], mem[0]} !== 32'hDEADBEEF) begin
      $display("FAIL write_mem got=%h exp=%h", {mem[1], mem[0]}, 32'hDEADBEEF);
      errors++;
    end
  endtask

  task automatic test_read;
    run_access(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      $display("FAIL readback got=%h exp=%h", read_data, 32'hDEADBEEF);
      errors++;
    end
    run_access(1'b0, 1'b1, 32'd1028, 32'h0BADF00D, 1'b0);
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      $display("FAIL read_hold got=%h exp=%h", read_data, 32'hDEADBEEF);
      errors++;
    end
  endtask

  task automatic test_translation;
    mem[4] = 16'h5678; mem[5] = 16'h1234;
    run_access(1'b1, 1'b0, 32'd1032, 32'h0, 1'b0);
    checks++;
    if (read_data !== 32'h12345678) begin
      $display("FAIL xlate_1032 got=%h exp=%h", read_data, 32'h12345678);
      errors++;
    end
    run_access(1'b0, 1'b1, 32'd1020, 32'hCAFEF00D, 1'b0);
    checks++;
    if ({mem[18'h3FFFF], mem[18'h3FFFE]} !== 32'hCAFEF00D) begin
      $display("FAIL xlate_wrap got=%h exp=%h", {mem[18'h3FFFF], mem[18'h3FFFE]}, 32'hCAFEF00D);
      errors++;
    end
  endtask

  task automatic test_conflict;
    run_access(1'b1, 1'b1, 32'd1040, 32'h13572468, 1'b0);
    checks++;
    if ({mem[9], mem[8]} !== 32'h13572468) begin
      $display("FAIL conflict_mem got=%h exp=%h", {mem[9], mem[8]}, 32'h13572468);
      errors++;
    end
  endtask

  task automatic test_back_to_back;
    mem[12] = 16'h3344; mem[13] = 16'h1122;
    run_access(1'b1, 1'b0, 32'd1048, 32'h0, 1'b1);
    run_access(1'b1, 1'b0, 32'd1048, 32'h0, 1'b0);
    checks++;
    if (read_data !== 32'h11223344) begin
      $display("FAIL b2b_data got=%h exp=%h", read_data, 32'h11223344);
      errors++;
    end
  endtask

  task automatic test_wait_states;
    int first0, first3, n_lo, n_hi, exp_lat;
    lat_q.push_back(3);
    lat_q.push_back(9);
    @(posedge clk); #1;
    ws_addr = 32'd1040; ws_data = 32'hA5A55A5A; w0_wr = 1'b1; w3_wr = 1'b1;
    first0 = -1; first3 = -1; n_lo = 0; n_hi = 0;
    for (int c = 0; c < 16; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      if (w0_ready && first0 < 0) begin first0 = c; w0_wr = 1'b0; end
      if (w3_ready && first3 < 0) begin first3 = c; w3_wr = 1'b0; end
      if (!w3_we_n && w3_addr == 18'd8) n_lo++;
      if (!w3_we_n && w3_addr == 18'd9) n_hi++;
    end
    w0_wr = 1'b0; w3_wr = 1'b0;
    exp_lat = lat_q.pop_front();
    checks++;
    if (first0 !== exp_lat) begin
      $display("FAIL wait0_latency got=%0d exp=%0d", first0, exp_lat);
      errors++;
    end
    exp_lat = lat_q.pop_front();
    checks++;
    if (first3 !== exp_lat) begin
      $display("FAIL wait3_latency got=%0d exp=%0d", first3, exp_lat);
      errors++;
    end
    checks++;
    if (n_lo !== 4 || n_hi !== 4) begin
      $display("FAIL wait3_phase_len got lo=%0d hi=%0d exp 4 and 4", n_lo, n_hi);
      errors++;
    end
  endtask

`ifdef SRAM_CTRL_ACCESS_COUNT_EN
  task automatic test_counters;
    @(posedge clk); #2;
    checks++;
    if (rd_count !== 16'(exp_rd_cnt) || wr_count !== 16'(exp_wr_cnt)) begin
      $display("FAIL counts got rd=%0d wr=%0d exp rd=%0d wr=%0d", rd_count, wr_count, exp_rd_cnt, exp_wr_cnt);
      errors++;
    end
    checks++;
    if ({w0_rdc, w0_wrc, w3_rdc, w3_wrc} !== {16'd0, 16'd1, 16'd0, 16'd1}) begin
      $display("FAIL ws_counts got w0=%0d/%0d w3=%0d/%0d exp 0/1 0/1", w0_rdc, w0_wrc, w3_rdc, w3_wrc);
      errors++;
    end
  endtask
`endif

  task automatic test_reset_mid_access;
    mem[12] = 16'h5555; mem[13] = 16'hAAAA;
    @(posedge clk); #1;
    wr_en = 1'b1; address = 32'd1048; write_data = 32'h99997777;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sram_addr !== 18'd13 || sram_we_n !== 1'b0) begin
      $display("FAIL mid_high got addr=%h we_n=%b exp addr=d we_n=0", sram_addr, sram_we_n);
      errors++;
    end
    rst = 1'b0; wr_en = 1'b0;
    #1;
    checks++;
    if ({sram_we_n, sram_dq_oe, ready, sram_addr, read_data} !== {1'b1, 1'b0, 1'b1, 18'h0, 32'h0}) begin
      $display("FAIL mid_reset got we_n=%b oe=%b rdy=%b addr=%h rd=%h exp 1 0 1 0 0",
               sram_we_n, sram_dq_oe, ready, sram_addr, read_data);
      errors++;
    end
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    checks++;
    if ({rd_count, wr_count} !== 32'h0) begin
      $display("FAIL mid_reset_counts got rd=%0d wr=%0d exp 0", rd_count, wr_count);
      errors++;
    end
`endif
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if ({mem[13], mem[12]} !== 32'hAAAA7777) begin
      $display("FAIL mid_reset_mem got=%h exp=%h", {mem[13], mem[12]}, 32'hAAAA7777);
      errors++;
    end
    rst = 1'b1;
    last_rd = 32'h0; exp_rd_cnt = 0; exp_wr_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0;
    test_reset;
    test_write;
    test_read;
    test_translation;
    test_conflict;
    test_back_to_back;
    test_wait_states;
`ifdef SRAM_CTRL_ACCESS_COUNT_EN
    test_counters;
`endif
    test_reset_mid_access;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
